// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage: valid/ready handshake on both sides, a 2-entry skid buffer
// with a registered ready, flush, bubble/x0-safe rd_we and a saturating stall counter.
//
// state | meaning
// EMPTY | no instruction held, outputs invalid
// BUSY  | main register M holds the EX-side instruction, skid S empty
// FULL  | M and S both hold instructions, upstream is stalled
module id_ex_pipe_stage #(
    parameter int PC_WIDTH  = 10,
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic [6:0]           opcode_i,
    input  logic [6:0]           funct7_i,
    input  logic [2:0]           funct3_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic                 rd_we_i,
    input  logic [4:0]           rd_addr_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [6:0]           opcode,
    output logic [6:0]           funct7,
    output logic [2:0]           funct3,
    output logic [XLEN-1:0]      imm,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 rd_we,
    output logic [4:0]           rd_addr,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [6:0]          funct7;
        logic [2:0]          funct3;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic                rd_we;
        logic [4:0]          rd_addr;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t   state;
    state_t   state_nxt;
    payload_t m_q;
    payload_t s_q;
    payload_t in_pl;
    logic     in_ready_q;
    logic     acc;
    logic     deq;
    logic     load_m;
    logic     load_s;
    logic     shift;

    assign in_pl = '{
        pc:       pc_i,
        opcode:   opcode_i,
        funct7:   funct7_i,
        funct3:   funct3_i,
        imm:      imm_i,
        rs1_addr: rs1_addr_i,
        rs2_addr: rs2_addr_i,
        rs1_data: rs1_data_i,
        rs2_data: rs2_data_i,
        rd_we:    rd_we_i,
        rd_addr:  rd_addr_i
    };

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign deq       = out_valid & out_ready;

    // flush overrides every transition; payload registers are left stale on purpose
    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        shift     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        load_m    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && !deq) begin
                        load_s    = 1'b1;
                        state_nxt = FULL;
                    end else if (acc && deq) begin
                        load_m    = 1'b1;
                    end else if (deq) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        shift     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            m_q        <= '0;
            s_q        <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (load_m) begin
                m_q <= in_pl;
            end else if (shift) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_pl;
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    assign pc       = m_q.pc;
    assign opcode   = m_q.opcode;
    assign funct7   = m_q.funct7;
    assign funct3   = m_q.funct3;
    assign imm      = m_q.imm;
    assign rs1_addr = m_q.rs1_addr;
    assign rs2_addr = m_q.rs2_addr;
    assign rs1_data = m_q.rs1_data;
    assign rs2_data = m_q.rs2_data;
    assign rd_addr  = m_q.rd_addr;
    // a bubble or a write to x0 must never reach the register file
    assign rd_we    = m_q.rd_we & out_valid & (m_q.rd_addr != 5'd0);

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed vectors against a queue-based model of the stage,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_id_ex_pipe_stage;

    localparam int PW = 10;
    localparam int XL = 32;
    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pc_i = '0;
    logic [6:0]    opcode_i = '0;
    logic [6:0]    funct7_i = '0;
    logic [2:0]    funct3_i = '0;
    logic [XL-1:0] imm_i = '0;
    logic [4:0]    rs1_addr_i = '0;
    logic [4:0]    rs2_addr_i = '0;
    logic [XL-1:0] rs1_data_i = '0;
    logic [XL-1:0] rs2_data_i = '0;
    logic          rd_we_i = 1'b0;
    logic [4:0]    rd_addr_i = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] pc;
    logic [6:0]    opcode;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic [XL-1:0] imm;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [XL-1:0] rs1_data;
    logic [XL-1:0] rs2_data;
    logic          rd_we;
    logic [4:0]    rd_addr;
    logic [CW-1:0] stall_cnt;

    id_ex_pipe_stage #(.PC_WIDTH(PW), .XLEN(XL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .opcode_i(opcode_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .opcode(opcode), .funct7(funct7), .funct3(funct3), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pc;
        logic [6:0]    opcode;
        logic [6:0]    funct7;
        logic [2:0]    funct3;
        logic [XL-1:0] imm;
        logic [4:0]    rs1_addr;
        logic [4:0]    rs2_addr;
        logic [XL-1:0] rs1_data;
        logic [XL-1:0] rs2_data;
        logic          rd_we;
        logic [4:0]    rd_addr;
    } ins_t;

    // model: the stage is a FIFO of at most two accepted instructions
    ins_t q[$];
    bit   m_ready = 1'b1;
    int   m_stall = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic [4:0] rd, input logic we, input logic v);
        pc_i       = PW'(p);
        opcode_i   = 7'(p * 3 + 1);
        funct7_i   = 7'(p >> 2);
        funct3_i   = 3'(p);
        imm_i      = (32'(p) * 32'h0101_0101) ^ 32'h5A5A_0000;
        rs1_addr_i = 5'(p >> 2);
        rs2_addr_i = 5'((p >> 3) + 1);
        rs1_data_i = ~imm_i;
        rs2_data_i = imm_i + 32'(p);
        rd_we_i    = we;
        rd_addr_i  = rd;
        in_valid   = v;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin : model
        bit   acc;
        bit   deq;
        ins_t cur;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_ready = 1'b1;
                m_stall = 0;
            end else begin
                acc = in_valid && m_ready;
                deq = (q.size() > 0) && out_ready;
                if ((q.size() > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
                cur = '{pc_i, opcode_i, funct7_i, funct3_i, imm_i, rs1_addr_i, rs2_addr_i,
                        rs1_data_i, rs2_data_i, rd_we_i, rd_addr_i};
                if (flush) begin
                    q.delete();
                    m_ready = 1'b1;
                end else begin
                    if (deq) void'(q.pop_front());
                    if (acc) q.push_back(cur);
                    m_ready = (q.size() < 2);
                end
            end
        end
    end

    initial begin : compare
        bit exp_we;
        forever begin
            @(negedge clk);
            exp_we = (q.size() > 0) ? (q[0].rd_we && (q[0].rd_addr != 5'd0)) : 1'b0;
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("rd_we", 64'(rd_we), 64'(exp_we));
            if (q.size() > 0) begin
                check("pc", 64'(pc), 64'(q[0].pc));
                check("opcode", 64'(opcode), 64'(q[0].opcode));
                check("funct7", 64'(funct7), 64'(q[0].funct7));
                check("funct3", 64'(funct3), 64'(q[0].funct3));
                check("imm", 64'(imm), 64'(q[0].imm));
                check("rs1_addr", 64'(rs1_addr), 64'(q[0].rs1_addr));
                check("rs2_addr", 64'(rs2_addr), 64'(q[0].rs2_addr));
                check("rs1_data", 64'(rs1_data), 64'(q[0].rs1_data));
                check("rs2_data", 64'(rs2_data), 64'(q[0].rs2_data));
                check("rd_addr", 64'(rd_addr), 64'(q[0].rd_addr));
            end
        end
    end

    initial begin : stimulus
        logic [11:0] rdy_pat;
        rdy_pat = 12'b1011_0010_1101;
        drive(0, 5'd0, 1'b0, 1'b0);
        repeat (2) step();
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_imm", 64'(imm), 64'h0);
        check("rst_rs1_data", 64'(rs1_data), 64'h0);
        check("rst_opcode", 64'(opcode), 64'h0);
        check("rst_rd_addr", 64'(rd_addr), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        rst = 1'b1;

        // streaming at full rate
        out_ready = 1'b1;
        drive(0, 5'd1, 1'b1, 1'b1); step();
        check("stream_first_valid", 64'(out_valid), 64'h1);
        check("stream_pc0", 64'(pc), 64'h0);
        drive(4, 5'd2, 1'b1, 1'b1); step();
        check("stream_pc4", 64'(pc), 64'h4);
        drive(8, 5'd3, 1'b1, 1'b1); step();
        check("stream_pc8", 64'(pc), 64'h8);
        check("stream_in_ready", 64'(in_ready), 64'h1);
        drive(12, 5'd4, 1'b1, 1'b1); step();
        drive(0, 5'd0, 1'b0, 1'b0); step();
        check("stream_drained", 64'(out_valid), 64'h0);

        // backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        drive(16, 5'd4, 1'b1, 1'b1); step();
        check("bp_ready_busy", 64'(in_ready), 64'h1);
        drive(20, 5'd5, 1'b1, 1'b1); step();
        check("bp_ready_full", 64'(in_ready), 64'h0);
        check("bp_stall1", 64'(stall_cnt), 64'h1);
        drive(24, 5'd6, 1'b1, 1'b1); step();
        step();
        check("bp_stall3", 64'(stall_cnt), 64'h3);
        check("bp_hold_pc", 64'(pc), 64'h10);
        out_ready = 1'b1; step();
        check("bp_drain_14", 64'(pc), 64'h14);
        step();
        check("bp_drain_18", 64'(pc), 64'h18);
        drive(0, 5'd0, 1'b0, 1'b0); step();
        check("bp_empty", 64'(out_valid), 64'h0);
        check("bp_stall_kept", 64'(stall_cnt), 64'h3);

        // flush while FULL with an incoming instruction
        out_ready = 1'b0;
        drive(32, 5'd7, 1'b1, 1'b1); step();
        drive(36, 5'd8, 1'b1, 1'b1); step();
        drive(40, 5'd9, 1'b1, 1'b1); flush = 1'b1; step();
        flush = 1'b0; drive(0, 5'd0, 1'b0, 1'b0);
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_ready", 64'(in_ready), 64'h1);
        check("flush_rd_we", 64'(rd_we), 64'h0);
        check("flush_stall", 64'(stall_cnt), 64'h5);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_ghost", 64'(out_valid), 64'h0);
        end

        // rd_we gating
        drive(48, 5'd0, 1'b1, 1'b1); step();
        check("x0_valid", 64'(out_valid), 64'h1);
        check("x0_rd_we", 64'(rd_we), 64'h0);
        drive(52, 5'd5, 1'b1, 1'b1); step();
        check("x5_rd_we", 64'(rd_we), 64'h1);
        check("x5_rd_addr", 64'(rd_addr), 64'h5);
        drive(56, 5'd7, 1'b0, 1'b1); step();
        check("nowe_rd_we", 64'(rd_we), 64'h0);
        drive(0, 5'd0, 1'b0, 1'b0); step();

        // asynchronous reset between edges while FULL
        out_ready = 1'b0;
        drive(64, 5'd1, 1'b1, 1'b1); step();
        drive(68, 5'd2, 1'b1, 1'b1); step();
        drive(0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_ready", 64'(in_ready), 64'h1);
        check("arst_pc", 64'(pc), 64'h0);
        check("arst_rs2_data", 64'(rs2_data), 64'h0);
        check("arst_stall", 64'(stall_cnt), 64'h0);
        check("arst_rd_we", 64'(rd_we), 64'h0);
        step();
        rst = 1'b1; out_ready = 1'b1;
        drive(80, 5'd3, 1'b1, 1'b1); step();
        check("arst_first_pc", 64'(pc), 64'h50);
        drive(0, 5'd0, 1'b0, 1'b0); step();
        check("arst_drained", 64'(out_valid), 64'h0);

        // stall counter saturation
        out_ready = 1'b0;
        drive(96, 5'd4, 1'b1, 1'b1); step();
        drive(0, 5'd0, 1'b0, 1'b0);
        repeat (20) step();
        check("sat_stall", 64'(stall_cnt), 64'hF);
        check("sat_pc", 64'(pc), 64'h60);
        out_ready = 1'b1; step();
        check("sat_drained", 64'(out_valid), 64'h0);
        check("sat_stall_kept", 64'(stall_cnt), 64'hF);

        // mixed backpressure pattern, checked against the model each cycle
        for (int i = 0; i < 12; i++) begin
            out_ready = rdy_pat[i];
            drive(128 + 4 * i, 5'(i), 1'b1, 1'b1);
            step();
        end
        drive(0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (4) step();
        check("pat_drained", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID->EX pipeline stage; successor to the plain ID/EX register.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so the ready path is fully registered.
- Adds a flush (branch/exception kill), rd_we gating against bubbles and x0, and a saturating backpressure counter.
- Sits between the decoder/register-file read stage and the ALU/EX stage.

Parameters:
PC_WIDTH, 10, width of pc payload
XLEN, 32, width of imm/rs1_data/rs2_data
CNT_WIDTH, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  kill all held and incoming instructions this cycle
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept (registered)
pc_i  in  PC_WIDTH  instruction PC
opcode_i  in  7  opcode
funct7_i  in  7  funct7
funct3_i  in  3  funct3
imm_i  in  XLEN  decoded immediate
rs1_addr_i  in  5  rs1 index (for EX forwarding)
rs2_addr_i  in  5  rs2 index
rs1_data_i  in  XLEN  rs1 value
rs2_data_i  in  XLEN  rs2 value
rd_we_i  in  1  destination write enable
rd_addr_i  in  5  destination index
out_valid  out  1  EX-side instruction valid
out_ready  in  1  EX accepts
pc, opcode, funct7, funct3, imm, rs1_addr, rs2_addr, rs1_data, rs2_data, rd_addr  out  as input  registered payload
rd_we  out  1  rd_we_reg AND out_valid AND (rd_addr != 0)
stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register M drives the outputs; skid register S holds one extra payload.
- FSM states: EMPTY (none valid), BUSY (M valid, S empty), FULL (M and S valid).
- Derived signals:
  - out_valid = (state != EMPTY)
  - in_ready = registered flag, 1 iff next state != FULL
  - acc = in_valid & in_ready
  - deq = out_valid & out_ready
- EMPTY: acc -> load M, go BUSY.
- BUSY:
  - acc & !deq -> load S, go FULL.
  - acc & deq -> load M, stay BUSY.
  - !acc & deq -> go EMPTY.
  - else hold.
- FULL: in_ready=0. deq -> M<=S, go BUSY. Else hold.
- Latency: an accepted instruction is visible on the outputs the cycle after acceptance when the stage is EMPTY/draining. Program order is always preserved.
- Throughput: 1 instruction/cycle when out_ready is held at 1.
- flush=1 (synchronous):
  - Next state EMPTY; in_ready<=1.
  - Any same-cycle input is dropped.
  - flush wins over acc and deq.
  - Payload registers keep stale values; only the valid bits clear.
- rd_we output is forced to 0 when out_valid=0 or rd_addr=0; no spurious writeback from a bubble.
- Payload registers load only on an accept/shift; they do not change when the stage holds (stall-safe).
- stall_cnt:
  - +1 each cycle out_valid & !out_ready, saturating at all-ones.
  - Not cleared by flush.
- Reset (rst=0, asynchronous):
  - state EMPTY, in_ready 1, out_valid 0, rd_we 0, stall_cnt 0.
  - All payload outputs 0: pc, opcode, funct7, funct3, imm, rs*_addr, rs*_data, rd_addr.
  - S cleared.
  - Deassertion takes effect at the next clk edge; reset mid-transfer discards everything.
- in_valid with in_ready=0: no acceptance; ID must hold its payload stable (no check inside the block).

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, pc_i=0,4,8,... -> first out_valid 1 cycle after first accept; pc out = 0,4,8 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 while sending pc 0x10, 0x14, 0x18:
  - 0x10 and 0x14 accepted; in_ready drops to 0 after the second accept; 0x18 held off.
  - stall_cnt counts each stalled cycle.
  - Raising out_ready drains 0x10, 0x14, 0x18 in order with no loss or duplication.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, rd_we=0; the flushed and incoming instructions never appear.
- rd_addr_i=0 with rd_we_i=1 (addi x0) -> rd_we output 0 while out_valid=1; rd_addr_i=5 -> rd_we=1.
- Async reset asserted mid-FULL, between clock edges -> outputs go to reset values immediately; after release, the next accepted instruction is the first seen.
- Saturation: with CNT_WIDTH=4, hold out_ready=0 for 20 cycles -> stall_cnt sticks at 15.
